// File: rtl/bcdn_counter.sv
// Multi-decade BCD up/down counter with validated parallel load, cascade strobe,
// sticky overflow flag and a one-cycle pulse on a rejected load.
module bcdn_counter #(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                x,
  input  logic                dir,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] bcdn_out,
  output logic                tc,
  output logic                ovf,
  output logic                err,
  output logic                zero
);

  localparam int W = 4 * DIGITS;

  logic         at_term;
  logic         din_ok;
  logic [W-1:0] step_val;

  function automatic logic nibbles_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic all_nines(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple carry across decades; all-nines naturally wraps to all-zeros.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple borrow across decades; all-zeros naturally wraps to all-nines.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    zero     = (bcdn_out == '0);
    at_term  = dir ? zero : all_nines(bcdn_out);
    tc       = x & ~clr & ~load & at_term;
    din_ok   = nibbles_valid(din);
    step_val = dir ? bcd_dec(bcdn_out) : bcd_inc(bcdn_out);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcdn_out <= '0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        bcdn_out <= '0;
        ovf      <= 1'b0;
      end else if (load) begin
        if (din_ok) bcdn_out <= din;
        else        err      <= 1'b1;
      end else if (x) begin
        if (tc) ovf <= 1'b1;
        // Saturating build freezes at the terminal value instead of wrapping.
        if (!(at_term && SAT)) bcdn_out <= step_val;
      end
    end
  end

endmodule

// File: tb/tb_bcdn_counter.sv
// Directed bench for bcdn_counter: a wrapping and a saturating instance share
// the same stimulus and are checked against hand-computed values.
module tb_bcdn_counter;

  logic        clk = 1'b0;
  logic        reset, x, dir, clr, load;
  logic [15:0] din;
  logic [15:0] w_out, s_out;
  logic        w_tc, w_ovf, w_err, w_zero;
  logic        s_tc, s_ovf, s_err, s_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcdn_counter #(.DIGITS(4), .SAT(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .x(x), .dir(dir), .clr(clr), .load(load), .din(din),
    .bcdn_out(w_out), .tc(w_tc), .ovf(w_ovf), .err(w_err), .zero(w_zero)
  );

  bcdn_counter #(.DIGITS(4), .SAT(1'b1)) u_sat (
    .clk(clk), .reset(reset), .x(x), .dir(dir), .clr(clr), .load(load), .din(din),
    .bcdn_out(s_out), .tc(s_tc), .ovf(s_ovf), .err(s_err), .zero(s_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    x = 1'b0; clr = 1'b0; load = 1'b1; din = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; x = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; din = 16'h0;
    #2 reset = 1'b0;
    #1;
    check("rst_out",  w_out, 16'h0000);
    check("rst_zero", w_zero, 1'b1);
    check("rst_ovf",  w_ovf, 1'b0);
    check("rst_err",  s_err, 1'b0);
    @(negedge clk) reset = 1'b1;

    // Count up ten steps from reset
    x = 1'b1; dir = 1'b0;
    #1;
    check("up_zero_pre", w_zero, 1'b1);
    check("up_tc_pre",   w_tc,   1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("up_tc", w_tc, 1'b0);
      check("up_zero", w_zero, 1'b0);
    end
    check("up10_w", w_out, 16'h0010);
    check("up10_s", s_out, 16'h0010);

    // Up wrap vs saturate
    do_load(16'h9998);
    check("ld9998", w_out, 16'h9998);
    x = 1'b1; dir = 1'b0;
    tick();
    check("9999_w",   w_out, 16'h9999);
    check("tc9999_w", w_tc,  1'b1);
    check("ovf_pre",  w_ovf, 1'b0);
    tick();
    check("wrap_w",   w_out, 16'h0000);
    check("wrap_s",   s_out, 16'h9999);
    check("ovf_w",    w_ovf, 1'b1);
    check("ovf_s",    s_ovf, 1'b1);
    check("tc_wrap0", w_tc,  1'b0);
    tick();
    check("0001_w",   w_out, 16'h0001);
    check("hold_s",   s_out, 16'h9999);
    check("ovf_w2",   w_ovf, 1'b1);

    // Clear, then down to terminal
    x = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_out", s_out, 16'h0000);
    check("clr_ovf", s_ovf, 1'b0);
    do_load(16'h0001);
    x = 1'b1; dir = 1'b1;
    tick();
    check("dn0_w",   w_out, 16'h0000);
    check("dn0_s",   s_out, 16'h0000);
    check("dn_ovf",  s_ovf, 1'b0);
    check("dn_tc_s", s_tc,  1'b1);
    check("dn_tc_w", w_tc,  1'b1);
    tick();
    check("dnwrap_w", w_out, 16'h9999);
    check("dnsat_s",  s_out, 16'h0000);
    check("dnovf_s",  s_ovf, 1'b1);
    check("dnovf_w",  w_ovf, 1'b1);
    tick();
    check("dn9998_w", w_out, 16'h9998);
    check("dnsat2_s", s_out, 16'h0000);

    // Rejected then accepted load
    do_load(16'h12A4);
    check("bad_ld_w", w_out, 16'h9998);
    check("bad_ld_s", s_out, 16'h0000);
    check("err_hi",   w_err, 1'b1);
    tick();
    check("err_lo",   w_err, 1'b0);
    do_load(16'h1234);
    check("ld1234",   w_out, 16'h1234);
    check("err_ok",   s_err, 1'b0);
    check("ld_ovf",   w_ovf, 1'b1);

    // Priority clr > load > x
    do_load(16'h0500);
    clr = 1'b1; load = 1'b1; x = 1'b1; din = 16'h1234; dir = 1'b0;
    #1;
    check("prio_tc", w_tc, 1'b0);
    tick();
    check("prio_clr", w_out, 16'h0000);
    check("prio_ovf", w_ovf, 1'b0);
    clr = 1'b0; din = 16'h0042;
    tick();
    check("ld_wins", w_out, 16'h0042);
    load = 1'b0;

    // Direction change with no dead cycle
    tick();
    check("dir_up", w_out, 16'h0043);
    dir = 1'b1;
    tick();
    check("dir_dn", w_out, 16'h0042);
    tick();
    check("dir_dn2", w_out, 16'h0041);

    // Borrow and carry across decades
    do_load(16'h1000);
    x = 1'b1; dir = 1'b1;
    tick();
    check("borrow", w_out, 16'h0999);
    dir = 1'b0;
    tick();
    check("carry", w_out, 16'h1000);

    // tc masked by load
    do_load(16'h9999);
    x = 1'b1; dir = 1'b0; load = 1'b1; din = 16'h9999;
    #1;
    check("tc_ld_mask", w_tc, 1'b0);
    load = 1'b0;
    #1;
    check("tc_unmask", w_tc, 1'b1);
    x = 1'b0;

    // Asynchronous reset mid-count
    do_load(16'h0733);
    x = 1'b1; dir = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out", w_out, 16'h0000);
    check("arst_ovf", w_ovf, 1'b0);
    check("arst_zero", w_zero, 1'b1);
    tick();
    check("arst_hold", w_out, 16'h0000);
    @(negedge clk) reset = 1'b1;
    tick();
    check("resume", w_out, 16'h0001);
    check("resume_s", s_out, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
